hazard_scoreboard: RTL
======================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised hazard controller for the in-order RV64I pipeline. It replaces
//  the fixed one-cycle load-use check with a per-register latency scoreboard.
//  It also handles EX-stage redirect flushes and whole-pipeline memory stalls.
//  Sits beside the ID stage and drives PC, IF/ID and ID/EX register controls.
// PARAMETERS
//  NREGS    32  architectural registers; register 0 is never tracked
//  REG_AW   5   register index width, equal to $clog2(NREGS)
//  MAX_LAT  4   max extra cycles before a result becomes forwardable
//  LAT_W    3   counter width, equal to $clog2(MAX_LAT+1)
//  CNT_W    16  width of the performance counters
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       synchronous reset, active high
//  id_valid       in   1       ID holds a real instruction
//  id_rs1         in   REG_AW  source register 1
//  id_rs1_used    in   1       instruction reads rs1
//  id_rs2         in   REG_AW  source register 2
//  id_rs2_used    in   1       instruction reads rs2
//  id_rd          in   REG_AW  destination register
//  id_rd_we       in   1       instruction writes rd
//  id_lat         in   LAT_W   extra cycles (ALU=0, load=1, multi-cycle >1)
//  ex_redirect    in   1       branch/jump resolved taken in EX this cycle
//  mem_stall      in   1       data memory not ready; freeze whole pipeline
//  stall_if       out  1       hold PC
//  stall_id       out  1       hold IF/ID
//  hold_ex        out  1       hold ID/EX and later stages (mem_stall only)
//  bubble_ex      out  1       load NOP into ID/EX
//  flush_if_id    out  1       clear IF/ID
//  flush_id_ex    out  1       clear ID/EX
//  issue          out  1       ID instruction advances to EX this cycle
//  perf_stall_cnt out  CNT_W   cycles with data-hazard stall (optional)
//  perf_flush_cnt out  CNT_W   redirect flushes seen (optional)
// BEHAVIOUR
//  - State: busy[r] is an LAT_W down-counter for each r in 1..NREGS-1.
//    busy[0] reads as 0 at all times.
//  - Reset (rst=1 at a clk edge): all busy counters and perf counters clear to 0.
//    While rst=1, every output is 0.
//  - dep   = id_valid && ((id_rs1_used && busy[id_rs1]!=0) ||
//            (id_rs2_used && busy[id_rs2]!=0)).
//  - Output priority (first match applies):
//    - mem_stall: stall_if=stall_id=hold_ex=1; all other outputs 0; busy frozen.
//      ex_redirect is ignored; its source holds it until mem_stall drops.
//    - ex_redirect: flush_if_id=flush_id_ex=1; stall_*=bubble_ex=issue=0.
//    - dep: stall_if=stall_id=bubble_ex=1; issue=0.
//    - otherwise: issue=id_valid; all control outputs 0.
//  - All outputs are combinational from the current inputs and busy state.
//  - Per-cycle update when mem_stall=0:
//    - Every nonzero busy counter decrements by 1.
//    - If issue && id_rd_we && id_rd!=0: busy[id_rd] <= min(id_lat,MAX_LAT).
//      The set overrides the decrement. A newer write with id_lat=0 clears the
//      entry (WAW: the newer value forwards).
//  - Latency semantics: a load issued at cycle t sets busy=1 at t+1. A dependent
//    instruction in ID at t+1 stalls one cycle and issues at t+2.
//  - A flushed ID instruction never touches the scoreboard.
//  - Already-issued older instructions keep their counters across a redirect.
//  - rs1==rs2 with both used counts as one dependency.
//  - x0 sources never stall.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//   - perf_stall_cnt increments on each cycle with the dep stall applied.
//   - perf_flush_cnt increments on each cycle with ex_redirect applied.
//   - Both wrap at 2^CNT_W and clear on rst.
//  HAZARD_PERF_CNT_EN undefined: both ports tied to 0; no counter flops.
// TESTING
//  - Load x5 (lat=1), then add x6,x5,x1 in ID next cycle -> 1 cycle of
//    stall_if/stall_id/bubble_ex=1, then issue=1.
//  - lat=3 write to x7, then a reader of x7 -> stalls exactly 3 cycles.
//    A reader of x8 in the same slot never stalls.
//  - Load x0 followed by a reader of x0 -> no stall, issue=1.
//  - ex_redirect=1 with dep=1 -> flush_if_id=flush_id_ex=1, stall=0.
//    The flushed rd is not marked busy.
//  - busy[x5]=1 with mem_stall=1 for 4 cycles -> hold_ex=1, busy stays 1.
//    After release, the reader stalls 1 more cycle.
//  - Perf, with macro: 2 dep stalls + 1 redirect -> perf_stall_cnt=2,
//    perf_flush_cnt=1. Without macro, both read 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard controller for the in-order RV64I pipeline, sitting beside ID.
//   Keeps a per-register latency scoreboard (one down-counter per architectural
//   register, x0 never tracked) and drives PC, IF/ID and ID/EX controls for
//   data-hazard stalls, EX redirect flushes and whole-pipeline memory stalls.
//
//   Optional feature macro: HAZARD_PERF_CNT_EN
//     defined   : o_perf_stall_cnt / o_perf_flush_cnt are live wrapping counters
//     undefined : both ports tied to 0, no counter flops
//
// Ports
//   i_clk, i_rst           clock (rising edge), synchronous active-high reset
//   i_id_*                 ID-stage instruction: valid, sources, destination, latency
//   i_ex_redirect          taken branch/jump resolved in EX
//   i_mem_stall            data memory not ready, freeze whole pipeline
//   o_stall_if/o_stall_id  hold PC / hold IF/ID
//   o_hold_ex              hold ID/EX and later (memory stall only)
//   o_bubble_ex            load NOP into ID/EX
//   o_flush_if_id/_id_ex   clear IF/ID / ID/EX
//   o_issue                ID instruction advances to EX this cycle
//   o_perf_stall_cnt       data-hazard stall cycles
//   o_perf_flush_cnt       redirect flushes applied
module hazard_scoreboard #(
  parameter int NREGS   = 32,
  parameter int REG_AW  = 5,
  parameter int MAX_LAT = 4,
  parameter int LAT_W   = 3,
  parameter int CNT_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic              i_id_rs1_used,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_rs2_used,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_rd_we,
  input  logic [LAT_W-1:0]  i_id_lat,
  input  logic              i_ex_redirect,
  input  logic              i_mem_stall,
  output logic              o_stall_if,
  output logic              o_stall_id,
  output logic              o_hold_ex,
  output logic              o_bubble_ex,
  output logic              o_flush_if_id,
  output logic              o_flush_id_ex,
  output logic              o_issue,
  output logic [CNT_W-1:0]  o_perf_stall_cnt,
  output logic [CNT_W-1:0]  o_perf_flush_cnt
);

  // Entry 0 is cleared on reset and never written afterwards, so x0 reads idle.
  logic [LAT_W-1:0] r_busy [NREGS];

  logic             w_rs1_busy;
  logic             w_rs2_busy;
  logic             w_dep;
  logic             w_dep_stall;
  logic             w_flush;
  logic [LAT_W-1:0] w_lat_sat;

  assign w_rs1_busy = i_id_rs1_used && (r_busy[i_id_rs1] != '0);
  assign w_rs2_busy = i_id_rs2_used && (r_busy[i_id_rs2] != '0);
  assign w_dep      = i_id_valid && (w_rs1_busy || w_rs2_busy);
  assign w_lat_sat  = (i_id_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : i_id_lat;

  // Priority: reset > memory stall > redirect > data hazard > issue.
  always_comb begin
    o_stall_if    = 1'b0;
    o_stall_id    = 1'b0;
    o_hold_ex     = 1'b0;
    o_bubble_ex   = 1'b0;
    o_flush_if_id = 1'b0;
    o_flush_id_ex = 1'b0;
    o_issue       = 1'b0;
    w_dep_stall   = 1'b0;
    w_flush       = 1'b0;
    if (!i_rst) begin
      if (i_mem_stall) begin
        o_stall_if = 1'b1;
        o_stall_id = 1'b1;
        o_hold_ex  = 1'b1;
      end else if (i_ex_redirect) begin
        o_flush_if_id = 1'b1;
        o_flush_id_ex = 1'b1;
        w_flush       = 1'b1;
      end else if (w_dep) begin
        o_stall_if  = 1'b1;
        o_stall_id  = 1'b1;
        o_bubble_ex = 1'b1;
        w_dep_stall = 1'b1;
      end else begin
        o_issue = i_id_valid;
      end
    end
  end

  // A fresh set from the issuing instruction wins over the decrement, so a
  // newer zero-latency write to the same rd clears the entry (WAW).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < NREGS; r++) r_busy[r] <= '0;
    end else if (!i_mem_stall) begin
      for (int r = 1; r < NREGS; r++) begin
        if (o_issue && i_id_rd_we && (i_id_rd == REG_AW'(r)))
          r_busy[r] <= w_lat_sat;
        else if (r_busy[r] != '0)
          r_busy[r] <= r_busy[r] - LAT_W'(1);
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_perf_stall;
  logic [CNT_W-1:0] r_perf_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_dep_stall) r_perf_stall <= r_perf_stall + CNT_W'(1);
      if (w_flush)     r_perf_flush <= r_perf_flush + CNT_W'(1);
    end
  end

  assign o_perf_stall_cnt = r_perf_stall;
  assign o_perf_flush_cnt = r_perf_flush;
`else
  logic w_unused_perf;
  assign w_unused_perf    = w_dep_stall ^ w_flush;
  assign o_perf_stall_cnt = '0;
  assign o_perf_flush_cnt = '0;
`endif

endmodule
